port_io_responder: RTL and testbench
====================================

PORT_IO_RESPONDER -- requirements
Module: port_io_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h40, port window base; bits [2:0] ignored; 8 registers decoded.
REQ-002 SHALL have parameter PRESCALE, default 16, number of clk_i cycles per timer tick; legal range 1..256.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named clk_i and rst_i.
REQ-004 SHALL have these ports:
  clk_i  in  1  clock
  rst_i  in  1  asynchronous active-high reset
  port_addr_i  in  8  port address from core
  port_dat_i  in  8  write data from core
  port_we_i  in  1  write strobe, one cycle
  port_re_i  in  1  read strobe, one cycle
  port_dat_o  out  8  registered read data to core
  port_ack_o  out  1  one-cycle acknowledge
  gpio_in_i  in  8  asynchronous external inputs
  gpio_out_o  out  8  GPIO output register
  int_req_o  out  1  interrupt request, level
  int_ack_i  in  1  interrupt acknowledge pulse from core

Function
REQ-005 SHALL decode a hit when port_addr_i[7:3] == BASE_ADDR[7:3]; offset = port_addr_i[2:0].
REQ-006 SHALL map: 0 GPIO_OUT rw; 1 GPIO_IN ro; 2 RELOAD rw; 3 CTRL rw (bit0 EN, bit1 AUTO, bit2 IRQ_EN, bits[7:3] read 0); 4 STATUS (bit0 EXP, write-1-to-clear); 5 COUNT ro; 6-7 read 8'h00, writes ignored.
REQ-007 SHALL apply a hit write at the clk_i edge where port_we_i=1; register value visible from the next cycle.
REQ-008 SHALL on a hit read register port_dat_o at the edge where port_re_i=1; data and port_ack_o=1 valid the following cycle (latency 1).
REQ-009 SHALL pulse port_ack_o for exactly one cycle per hit strobe; no ack and port_dat_o=8'h00 on a miss or when idle.
REQ-010 SHALL on simultaneous port_we_i and port_re_i to a hit perform the write, return the pre-write value, and issue one ack.
REQ-011 SHALL synchronize gpio_in_i through two flops; GPIO_IN reads the second stage (2-cycle input latency).
REQ-012 SHALL generate a tick every PRESCALE cycles while EN=1; prescaler held at 0 while EN=0.
REQ-013 SHALL load COUNT from RELOAD on a CTRL write that sets EN from 0 to 1.
REQ-014 SHALL on a tick with COUNT>0 decrement COUNT; on a tick with COUNT==0 set EXP, then reload COUNT if AUTO=1, else clear EN and hold COUNT at 0.
REQ-015 SHALL drive int_req_o = EXP & IRQ_EN, combinationally from registered bits.
REQ-016 SHALL clear EXP on int_ack_i=1 or on a STATUS write with bit0=1.
REQ-017 SHALL give expiry priority over clear: if set and clear occur in the same cycle, EXP remains 1.
REQ-018 SHALL treat RELOAD=0 with AUTO=1 as expiry on every tick.

Reset
REQ-019 SHALL on rst_i asynchronously clear GPIO_OUT, RELOAD, CTRL, EXP, COUNT, prescaler, sync flops, port_dat_o and port_ack_o to 0; int_req_o becomes 0.
REQ-020 SHALL abandon any in-flight read or write on reset mid-access; no ack after release for strobes sampled during reset.

Configuration
REQ-021 SHALL include timer, STATUS and interrupt logic only when PORT_IO_TIMER_EN is defined.
REQ-022 SHALL without PORT_IO_TIMER_EN read offsets 2-5 as 8'h00, ignore writes to them, still ack hits, and tie int_req_o to 0.

Structure
REQ-023 SHALL place register offsets, CTRL/STATUS bit indices and data width constants in shared package port_io_pkg.
REQ-024 SHALL implement prescaler, COUNT, RELOAD load and EXP generation in sub-module port_timer.

Verification
REQ-025 SHALL test: write 8'hA5 to 8'h40 -> gpio_out_o=8'hA5 next cycle; read 8'h40 -> port_dat_o=8'hA5 with ack one cycle after strobe.
REQ-026 SHALL test: gpio_in_i=8'h3C, read 8'h41 three cycles later -> 8'h3C; read 8'h48 -> no ack, data 8'h00.
REQ-027 SHALL test: PRESCALE=4, RELOAD=2, CTRL=8'h05 -> EXP and int_req_o rise 12 cycles after enable; EN clears; COUNT reads 0.
REQ-028 SHALL test: AUTO=1, RELOAD=1 -> EXP every 8 cycles; int_ack_i clears int_req_o; ack coincident with expiry -> int_req_o stays 1.
REQ-029 SHALL test: rst_i asserted mid-count and during a read strobe -> all outputs 0 immediately, no ack after release.
REQ-030 SHALL test: build without PORT_IO_TIMER_EN -> write 8'hFF to 8'h42 then read 8'h42 -> 8'h00 with ack; int_req_o constantly 0.

Source files
------------

// File: rtl/port_io_pkg.sv
// Shared constants and types for the port I/O responder: register offsets,
// CTRL/STATUS bit positions, data widths and the CTRL register layout.
package port_io_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned OFF_W   = 3;
  localparam int unsigned PRESC_W = 8;

  localparam logic [OFF_W-1:0] OFF_GPIO_OUT = 3'd0;
  localparam logic [OFF_W-1:0] OFF_GPIO_IN  = 3'd1;
  localparam logic [OFF_W-1:0] OFF_RELOAD   = 3'd2;
  localparam logic [OFF_W-1:0] OFF_CTRL     = 3'd3;
  localparam logic [OFF_W-1:0] OFF_STATUS   = 3'd4;
  localparam logic [OFF_W-1:0] OFF_COUNT    = 3'd5;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned STATUS_EXP  = 0;

  typedef logic [DATA_W-1:0] data_t;

  // Field order matches the CTRL bit indices above (en is bit 0).
  typedef struct packed {
    logic irq_en;
    logic auto_rl;
    logic en;
  } ctrl_t;

  // CTRL as seen on the bus; unused upper bits read as zero.
  function automatic data_t ctrl_to_data(input ctrl_t c);
    return DATA_W'(c);
  endfunction

endpackage

// File: rtl/port_io_responder_if.sv
// Core-side port bus: address, write data, one-cycle strobes, read data and ack.
interface port_io_responder_if;
  import port_io_pkg::*;

  logic [ADDR_W-1:0] port_addr_i;
  logic [DATA_W-1:0] port_dat_i;
  logic              port_we_i;
  logic              port_re_i;
  logic [DATA_W-1:0] port_dat_o;
  logic              port_ack_o;

  modport master (
    output port_addr_i, port_dat_i, port_we_i, port_re_i,
    input  port_dat_o, port_ack_o
  );

  modport slave (
    input  port_addr_i, port_dat_i, port_we_i, port_re_i,
    output port_dat_o, port_ack_o
  );

endinterface

// File: rtl/port_timer.sv
// Down-counting timer: prescaler, COUNT/RELOAD, CTRL register and EXP flag.
// Only instantiated when PORT_IO_TIMER_EN is defined.
module port_timer
  import port_io_pkg::*;
#(
  parameter int unsigned PRESCALE = 16
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  reload_we,
  input  data_t reload_wdat,
  input  logic  ctrl_we,
  input  ctrl_t ctrl_wdat,
  input  logic  exp_clr,
  output data_t reload,
  output ctrl_t ctrl,
  output logic  expired,
  output data_t count
);

  logic [PRESC_W-1:0] presc;
  logic               tick;

  assign tick = ctrl.en && (presc == PRESC_W'(PRESCALE - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc   <= '0;
      reload  <= '0;
      ctrl    <= '0;
      expired <= 1'b0;
      count   <= '0;
    end else begin
      if (reload_we) reload <= reload_wdat;

      if (!ctrl.en || tick) presc <= '0;
      else                  presc <= presc + PRESC_W'(1);

      if (tick) begin
        if (count != '0)       count <= count - DATA_W'(1);
        else if (ctrl.auto_rl) count <= reload;
        else begin
          count   <= '0;
          ctrl.en <= 1'b0;
        end
      end

      // A bus write to CTRL overrides the timer's own EN clear in the same cycle.
      if (ctrl_we) begin
        ctrl <= ctrl_wdat;
        if (ctrl_wdat.en && !ctrl.en) count <= reload;
      end

      // Expiry wins over a coincident clear.
      if (tick && count == '0) expired <= 1'b1;
      else if (exp_clr)        expired <= 1'b0;
    end
  end

endmodule

// File: rtl/port_io_responder.sv
// Port-mapped GPIO/timer responder with an 8-register window at BASE_ADDR.
// Timer, STATUS and interrupt logic are built only with PORT_IO_TIMER_EN defined.
module port_io_responder
  import port_io_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h40,
  parameter int unsigned       PRESCALE  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  port_io_responder_if.slave  bus,
  input  logic [DATA_W-1:0]   gpio_in_i,
  output logic [DATA_W-1:0]   gpio_out_o,
  output logic                int_req_o,
  input  logic                int_ack_i
);

  logic             hit;
  logic [OFF_W-1:0] off;
  logic             wr_hit;
  logic             rd_hit;
  data_t            gpio_sync1;
  data_t            gpio_sync2;
  data_t            rdata;
  data_t            reload;
  data_t            count;
  ctrl_t            ctrl;
  logic             expired;

  assign hit    = bus.port_addr_i[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W];
  assign off    = bus.port_addr_i[OFF_W-1:0];
  assign wr_hit = hit && bus.port_we_i;
  assign rd_hit = hit && bus.port_re_i;

`ifdef PORT_IO_TIMER_EN
  port_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reload_we   (wr_hit && off == OFF_RELOAD),
    .reload_wdat (bus.port_dat_i),
    .ctrl_we     (wr_hit && off == OFF_CTRL),
    .ctrl_wdat   (ctrl_t'(bus.port_dat_i[CTRL_IRQ_EN:CTRL_EN])),
    .exp_clr     (int_ack_i || (wr_hit && off == OFF_STATUS && bus.port_dat_i[STATUS_EXP])),
    .reload      (reload),
    .ctrl        (ctrl),
    .expired     (expired),
    .count       (count)
  );

  assign int_req_o = expired & ctrl.irq_en;
`else
  localparam int unsigned unused_prescale = PRESCALE;
  logic unused_timer;

  assign unused_timer = int_ack_i;
  assign reload       = '0;
  assign count        = '0;
  assign ctrl         = '0;
  assign expired      = 1'b0;
  assign int_req_o    = 1'b0;
`endif

  // Read mux; values are taken before any same-cycle write lands.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_GPIO_OUT: rdata = gpio_out_o;
      OFF_GPIO_IN:  rdata = gpio_sync2;
      OFF_RELOAD:   rdata = reload;
      OFF_CTRL:     rdata = ctrl_to_data(ctrl);
      OFF_STATUS:   rdata = DATA_W'(expired);
      OFF_COUNT:    rdata = count;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpio_sync1     <= '0;
      gpio_sync2     <= '0;
      gpio_out_o     <= '0;
      bus.port_dat_o <= '0;
      bus.port_ack_o <= 1'b0;
    end else begin
      gpio_sync1     <= gpio_in_i;
      gpio_sync2     <= gpio_sync1;
      bus.port_ack_o <= wr_hit || rd_hit;
      bus.port_dat_o <= rd_hit ? rdata : '0;
      if (wr_hit && off == OFF_GPIO_OUT) gpio_out_o <= bus.port_dat_i;
    end
  end

endmodule

// File: tb/tb_port_io_responder.sv
// Scoreboard bench for port_io_responder; timer checks run when PORT_IO_TIMER_EN is defined.
module tb_port_io_responder;

  typedef struct {
    int         cyc;
    logic [7:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out;
  logic       int_req;
  logic       int_ack = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];

  port_io_responder_if bus();

  port_io_responder #(
    .BASE_ADDR (8'h40),
    .PRESCALE  (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .gpio_in_i  (gpio_in),
    .gpio_out_o (gpio_out),
    .int_req_o  (int_req),
    .int_ack_i  (int_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic is_hit(input logic [7:0] a);
    return a[7:3] == 5'b01000;
  endfunction

  // One bus strobe; a hit pushes the expected ack (next cycle) and read data.
  task automatic access(input logic [7:0] a, input logic [7:0] d,
                        input logic w, input logic r, input logic [7:0] rd_exp);
    exp_t e;
    @(negedge clk);
    bus.port_addr_i = a;
    bus.port_dat_i  = d;
    bus.port_we_i   = w;
    bus.port_re_i   = r;
    if (is_hit(a)) begin
      e.cyc = cyc + 1;
      e.dat = r ? rd_exp : 8'h00;
      q.push_back(e);
    end
    @(negedge clk);
    bus.port_we_i = 1'b0;
    bus.port_re_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    access(a, d, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] rd_exp);
    access(a, 8'h00, 1'b0, 1'b1, rd_exp);
  endtask

  initial begin
    bus.port_addr_i = 8'h00;
    bus.port_dat_i  = 8'h00;
    bus.port_we_i   = 1'b0;
    bus.port_re_i   = 1'b0;

    fork
      // Monitor: pops expected responses on ack, checks idle data is zero.
      forever begin
        exp_t e;
        @(negedge clk);
        if (bus.port_ack_o) begin
          if (q.size() == 0) begin
            chk("unexpected_ack", 8'h01, 8'h00);
          end else begin
            e = q.pop_front();
            chk("ack_cycle", 8'(cyc - e.cyc), 8'h00);
            chk("read_data", bus.port_dat_o, e.dat);
          end
        end else begin
          if (q.size() != 0 && q[0].cyc < cyc) begin
            void'(q.pop_front());
            chk("missing_ack", 8'h00, 8'h01);
          end
          chk("idle_data", bus.port_dat_o, 8'h00);
        end
`ifndef PORT_IO_TIMER_EN
        chk("int_req_tied", 8'(int_req), 8'h00);
`endif
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dat", bus.port_dat_o, 8'h00);
    chk("rst_ack", 8'(bus.port_ack_o), 8'h00);
    chk("rst_gpio_out", gpio_out, 8'h00);
    chk("rst_int_req", 8'(int_req), 8'h00);
    rst = 1'b0;

    // GPIO_OUT write and readback
    wr(8'h40, 8'hA5);
    chk("gpio_out_a5", gpio_out, 8'hA5);
    rd(8'h40, 8'hA5);

    // GPIO_IN through the synchronizer
    gpio_in = 8'h3C;
    repeat (2) @(negedge clk);
    rd(8'h41, 8'h3C);
    gpio_in = 8'hC3;
    rd(8'h41, 8'h3C);
    rd(8'h41, 8'hC3);

    // Misses: no ack, no effect
    rd(8'h48, 8'h00);
    rd(8'h3F, 8'h00);
    wr(8'h48, 8'hFF);
    chk("miss_write", gpio_out, 8'hA5);

    // Simultaneous write+read returns the pre-write value
    access(8'h40, 8'h5A, 1'b1, 1'b1, 8'hA5);
    chk("wr_rd_gpio_out", gpio_out, 8'h5A);
    rd(8'h40, 8'h5A);

    // Reserved offsets
    wr(8'h46, 8'hFF);
    rd(8'h46, 8'h00);
    rd(8'h47, 8'h00);

`ifdef PORT_IO_TIMER_EN
    // One-shot: PRESCALE=4, RELOAD=2 -> expiry 12 cycles after enable
    wr(8'h42, 8'h02);
    rd(8'h42, 8'h02);
    wr(8'h43, 8'h05);
    repeat (11) @(negedge clk);
    chk("oneshot_int_before", 8'(int_req), 8'h00);
    @(negedge clk);
    chk("oneshot_int_after", 8'(int_req), 8'h01);
    rd(8'h43, 8'h04);
    rd(8'h45, 8'h00);
    rd(8'h44, 8'h01);
    wr(8'h44, 8'h01);
    chk("w1c_int", 8'(int_req), 8'h00);
    rd(8'h44, 8'h00);

    // Auto-reload: RELOAD=1 -> expiry every 8 cycles
    wr(8'h42, 8'h01);
    wr(8'h43, 8'h07);
    repeat (7) @(negedge clk);
    chk("auto_int_before", 8'(int_req), 8'h00);
    @(negedge clk);
    chk("auto_int_first", 8'(int_req), 8'h01);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    chk("int_ack_clears", 8'(int_req), 8'h00);
    repeat (6) @(negedge clk);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    chk("expiry_beats_ack", 8'(int_req), 8'h01);
    wr(8'h43, 8'h00);
    wr(8'h44, 8'h01);
    chk("auto_stop_int", 8'(int_req), 8'h00);
    rd(8'h43, 8'h00);

    // Start a count for the reset-mid-count case below
    wr(8'h42, 8'h02);
    wr(8'h43, 8'h05);
    repeat (5) @(negedge clk);
`else
    // Timer registers absent
    wr(8'h42, 8'hFF);
    rd(8'h42, 8'h00);
    wr(8'h43, 8'h07);
    rd(8'h43, 8'h00);
    rd(8'h44, 8'h00);
    rd(8'h45, 8'h00);
    repeat (20) @(negedge clk);
    rd(8'h45, 8'h00);
`endif

    // Reset asserted together with a read strobe
    @(negedge clk);
    bus.port_addr_i = 8'h40;
    bus.port_re_i   = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_dat", bus.port_dat_o, 8'h00);
    chk("midrst_ack", 8'(bus.port_ack_o), 8'h00);
    chk("midrst_gpio_out", gpio_out, 8'h00);
    chk("midrst_int_req", 8'(int_req), 8'h00);
    @(negedge clk);
    bus.port_re_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd(8'h40, 8'h00);
    rd(8'h42, 8'h00);
    rd(8'h43, 8'h00);
    rd(8'h45, 8'h00);

    // Drain the scoreboard
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 8'(q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
